// File: rtl/dmem_responder.sv
// Multi-cycle word-organised data memory with valid/ready request and response channels.
// Optional DMEM_ALIGN_CHECK_EN macro reports misaligned half/word accesses as errors.
module dmem_responder #(
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic          f3_bad;
    logic          range_bad;
    logic          misalign;
    logic          acc_err;
    logic          access;
    logic          mem_we;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   merged;

    assign idx     = addr_q[AW+1:2];
    assign rd_word = mem[idx];

    // Legal stores are 000/001/010; legal loads additionally include 100/101.
    assign f3_bad    = write_q ? (f3_q[2] || (f3_q[1:0] == 2'b11))
                               : ((f3_q == 3'b011) || (f3_q[2:1] == 2'b11));
    assign range_bad = (addr_q >= LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign  = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                       ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    assign misalign  = 1'b0;
`endif
    assign acc_err   = f3_bad || range_bad || misalign;
    assign access    = (state == S_WAIT) && (cnt == 4'd0);
    assign mem_we    = access && write_q && !acc_err;

    // Half lanes use only addr[1] and words ignore addr[1:0], which forces alignment.
    assign lane_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    assign lane_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (f3_q)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, lane_byte};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        wd = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM and survives rst.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx] <= merged;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            f3_q       <= 3'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        f3_q      <= req_funct3;
                        cnt       <= 4'(WAIT_CYC);
                        req_ready <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= (acc_err || write_q) ? 32'd0 : load_data;
                        resp_err   <= acc_err;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
